atctlc2axi500_rr_arb: RTL and testbench
=======================================

# atctlc2axi500_rr_arb

Burst-aware round-robin arbiter that shares one AXI-side channel among N requesters inside the TL-to-AXI bridge. It picks one requester, locks the channel to it until the beat flagged last completes, then advances the priority pointer. It drives the granted index in binary and, through the bridge's binary-to-one-hot converter, as a one-hot vector; the index and vector select the payload and route ready.

## Interface
- N, 4: number of requesters, 1..16.
- DW, 64: payload width per requester.
- W (localparam): max(1, $clog2(N)), width of the index.

- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester valid.
- req_last  in  N  per-requester last-beat flag, meaningful only while the matching valid is high.
- req_data  in  N*DW  flattened payload; requester i occupies bits [i*DW +: DW].
- req_ready  out  N  per-requester ready, one-hot or zero.
- out_valid  out  1  arbitrated valid.
- out_last  out  1  arbitrated last.
- out_data  out  DW  arbitrated payload.
- out_ready  in  1  downstream ready.
- gnt_idx  out  W  granted requester, binary.
- gnt_onehot  out  N  granted requester, one-hot. All zero in IDLE.
- busy  out  1  high while in GNT.

## Operation
- FSM states: IDLE and GNT. Registers: state, gnt_idx, ptr (W bits).
- IDLE:
  - If any req_valid is high, select the first set bit scanning from ptr upward, modulo N.
  - Load gnt_idx with that bit and go to GNT.
  - If no req_valid is high, stay in IDLE.
- GNT:
  - out_valid = req_valid[gnt_idx].
  - out_last = req_last[gnt_idx].
  - out_data = req_data slice gnt_idx.
  - req_ready = gnt_onehot & {N{out_ready}}.
  - A handshake is out_valid & out_ready.
  - On a handshake with out_last high: return to IDLE and set ptr = gnt_idx+1. The pointer wraps from N-1 to 0 even when N is not a power of 2.
  - A handshake without last keeps the grant.
  - If the granted requester drops valid mid-burst, the grant is still held. The block has no timeout.
- Outside GNT: out_valid=0, out_last=0, out_data=0, req_ready=0, gnt_onehot=0.
- Only the granted requester ever sees ready. Requests from all other requesters are ignored until the arbiter returns to IDLE.
- N=1: the scan always selects 0 and ptr stays 0. The IDLE/GNT sequencing is unchanged.
- Data are not buffered. out_data is combinational from req_data.

## Timing
- Reset values: state=IDLE, gnt_idx=0, ptr=0, busy=0. All outputs are 0.
- Reset asserted mid-burst aborts the burst immediately. The next cycle after release is IDLE with ptr=0.
- Arbitration latency: a request seen in IDLE in cycle t is granted in cycle t+1. out_valid can be high from t+1.
- Beat throughput inside a burst is one beat per cycle.
- Each burst costs one IDLE bubble cycle after the last beat completes. Peak utilisation is therefore L/(L+1) for L-beat bursts.
- Fairness: a continuously requesting requester waits at most N-1 bursts.
- No combinational path from out_ready to gnt_idx or state. req_ready depends combinationally on out_ready.

## Structure
- Submodule atctlc2axi500_bin2onehot #(.N(N)): converts gnt_idx to a raw one-hot; gnt_onehot = that vector gated by busy.
- Shared package atctlc2axi500_pkg holds:
  - the state encoding (IDLE=1'b0, GNT=1'b1);
  - the index-width function max(1, clog2(N)).
- The rotate-scan priority pick is a function within this block.

## Test plan
- After reset with N=4, ptr=0: req_valid=4'b1010, single-beat bursts, out_ready=1. Requester 1 is granted in cycle 1 and completes, with one IDLE cycle between bursts. Requester 3 is granted next, then requester 1 again. Each grant shows gnt_onehot = 4'b0010, 4'b1000, 4'b0010 in turn.
- Grant requester 2 for a 4-beat burst and toggle out_ready 1,0,1,1,0,1. The grant holds for exactly 4 handshakes. req_ready equals 4'b0100 & out_ready. Requester 0 waits the whole burst, even though it requests throughout.
- Wrap-around: N=3, ptr=2 (after a requester-1 burst), req_valid=3'b011. Requester 0 is granted, not requester 1. Afterwards ptr=1.
- Valid drop: requester 0 drops valid after beat 2 of 4, during which other requests are pending. out_valid=0, busy=1 and the grant is held. The burst completes when requester 0 resumes.
- Reset mid-burst: assert aresetn=0 on beat 2. All outputs are 0 combinationally. After release, the first grant obeys ptr=0 priority.
- Fairness soak: N=5, all requesters always valid, random burst lengths 1..8. Grants cycle 0,1,2,3,4,0 exactly, and no beat is lost or duplicated.

Source files
------------

// File: rtl/atctlc2axi500_pkg.sv
// Shared definitions for the TL-to-AXI bridge arbiter: FSM encoding and
// the index-width helper used to size binary grant indices.
package atctlc2axi500_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GNT  = 1'b1
  } arb_state_e;

  // A single requester still needs a 1-bit index so ports never collapse to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/atctlc2axi500_bin2onehot.sv
// Binary index to one-hot decoder shared by the bridge; an index outside
// 0..N-1 decodes to all zeros.
module atctlc2axi500_bin2onehot
  import atctlc2axi500_pkg::*;
#(
  parameter int N = 4,
  localparam int W = idx_width(N)
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = (idx == W'(i));
    end
  end

endmodule

// File: rtl/atctlc2axi500_rr_arb.sv
// Burst-aware round-robin arbiter: locks the AXI-side channel to one requester
// until its last beat completes, then rotates priority past that requester.
module atctlc2axi500_rr_arb
  import atctlc2axi500_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 64,
  localparam int W = idx_width(N)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  output logic          out_valid,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [W-1:0]  gnt_idx,
  output logic [N-1:0]  gnt_onehot,
  output logic          busy
);

  arb_state_e      state, state_n;
  logic [W-1:0]    gnt_n;
  logic [W-1:0]    ptr, ptr_n;
  logic [N-1:0]    raw_onehot;
  logic [DW-1:0]   slice [N];
  logic            handshake;

  // First set bit of valid, scanning upward from start and wrapping at N.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] valid,
                                           input logic [W-1:0] start);
    logic [W-1:0] sel;
    logic [W-1:0] pos;
    logic         found;
    int           j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      pos = W'(j);
      if (!found && valid[pos]) begin
        sel   = pos;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_slice
    assign slice[i] = req_data[i*DW +: DW];
  end

  atctlc2axi500_bin2onehot #(.N(N)) u_bin2onehot (
    .idx    (gnt_idx),
    .onehot (raw_onehot)
  );

  // Handshake: a beat moves when out_valid and out_ready are both high at the
  // rising edge of aclk. Only the granted requester sees req_ready, which
  // follows out_ready combinationally; valid never waits on ready.
  assign busy       = (state == ST_GNT);
  assign gnt_onehot = raw_onehot & {N{busy}};
  assign req_ready  = gnt_onehot & {N{out_ready}};
  assign out_valid  = busy & req_valid[gnt_idx];
  assign out_last   = busy & req_last[gnt_idx];
  assign out_data   = busy ? slice[gnt_idx] : '0;
  assign handshake  = out_valid & out_ready;

  always_comb begin
    state_n = state;
    gnt_n   = gnt_idx;
    ptr_n   = ptr;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          gnt_n   = rr_pick(req_valid, ptr);
          state_n = ST_GNT;
        end
      end
      ST_GNT: begin
        // A dropped valid mid-burst simply stalls here; the grant is kept.
        if (handshake && out_last) begin
          state_n = ST_IDLE;
          ptr_n   = (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= ST_IDLE;
      gnt_idx <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_n;
      gnt_idx <= gnt_n;
      ptr     <= ptr_n;
    end
  end

endmodule

// File: tb/tb_atctlc2axi500_rr_arb.sv
// Directed checks of the round-robin arbiter at N=4, N=3 and N=5.
`define CHK(tag, obs, exp) begin total++; assert ((obs) === (exp)) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

module tb_atctlc2axi500_rr_arb;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // N=4, DW=64 instance
  logic [3:0]   v4, l4, rr4, oh4;
  logic [255:0] d4;
  logic         ov4, ol4, or4, busy4;
  logic [63:0]  od4;
  logic [1:0]   gi4;

  // N=3, DW=16 instance
  logic [2:0]   v3, l3, rr3, oh3;
  logic [47:0]  d3;
  logic         ov3, ol3, or3, busy3;
  logic [15:0]  od3;
  logic [1:0]   gi3;

  // N=5, DW=16 instance
  logic [4:0]   v5, l5, rr5, oh5;
  logic [79:0]  d5;
  logic         ov5, ol5, or5, busy5;
  logic [15:0]  od5;
  logic [2:0]   gi5;

  atctlc2axi500_rr_arb #(.N(4), .DW(64)) u4 (
    .aclk(clk), .aresetn(aresetn), .req_valid(v4), .req_last(l4), .req_data(d4),
    .req_ready(rr4), .out_valid(ov4), .out_last(ol4), .out_data(od4),
    .out_ready(or4), .gnt_idx(gi4), .gnt_onehot(oh4), .busy(busy4)
  );

  atctlc2axi500_rr_arb #(.N(3), .DW(16)) u3 (
    .aclk(clk), .aresetn(aresetn), .req_valid(v3), .req_last(l3), .req_data(d3),
    .req_ready(rr3), .out_valid(ov3), .out_last(ol3), .out_data(od3),
    .out_ready(or3), .gnt_idx(gi3), .gnt_onehot(oh3), .busy(busy3)
  );

  atctlc2axi500_rr_arb #(.N(5), .DW(16)) u5 (
    .aclk(clk), .aresetn(aresetn), .req_valid(v5), .req_last(l5), .req_data(d5),
    .req_ready(rr5), .out_valid(ov5), .out_last(ol5), .out_data(od5),
    .out_ready(or5), .gnt_idx(gi5), .gnt_onehot(oh5), .busy(busy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    total++;
    if (rr4 !== (oh4 & {4{or4}})) begin
      bad++;
      $error("FAIL mon_rdy4 observed=%0h expected=%0h", rr4, oh4 & {4{or4}});
    end
    total++;
    if (rr3 !== (oh3 & {3{or3}})) begin
      bad++;
      $error("FAIL mon_rdy3 observed=%0h expected=%0h", rr3, oh3 & {3{or3}});
    end
    total++;
    if (rr5 !== (oh5 & {5{or5}})) begin
      bad++;
      $error("FAIL mon_rdy5 observed=%0h expected=%0h", rr5, oh5 & {5{or5}});
    end
    total++;
    if (ov4 !== (busy4 & v4[gi4])) begin
      bad++;
      $error("FAIL mon_valid4 observed=%0h expected=%0h", ov4, busy4 & v4[gi4]);
    end
    total++;
    if (ov3 !== (busy3 & v3[gi3])) begin
      bad++;
      $error("FAIL mon_valid3 observed=%0h expected=%0h", ov3, busy3 & v3[gi3]);
    end
    total++;
    if (ov5 !== (busy5 & v5[gi5])) begin
      bad++;
      $error("FAIL mon_valid5 observed=%0h expected=%0h", ov5, busy5 & v5[gi5]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic rdy_seq [6];
    int   seq [5];
    int   tot [5];
    int   g, len, beat, cyc;

    rdy_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      seq[i] = 0;
      tot[i] = 0;
    end
    v4 = '0; l4 = '0; or4 = 1'b0; d4 = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    v3 = '0; l3 = '0; or3 = 1'b0; d3 = {16'hC2, 16'hC1, 16'hC0};
    v5 = '0; l5 = '0; or5 = 1'b0; d5 = '0;

    // Reset state
    @(negedge clk);
    `CHK("rst_busy", busy4, 1'b0)
    `CHK("rst_onehot", oh4, 4'b0000)
    `CHK("rst_valid", ov4, 1'b0)
    `CHK("rst_ready", rr4, 4'b0000)
    `CHK("rst_idx", gi4, 2'd0)
    `CHK("rst_data", od4, 64'h0)
    `CHK("rst_last", ol4, 1'b0)
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Single-beat bursts from requesters 1 and 3
    v4 = 4'b1010; l4 = 4'b1111; or4 = 1'b1;
    @(negedge clk); `CHK("t1_idle0", busy4, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t1_g1_idx", gi4, 2'd1)
    `CHK("t1_g1_oh", oh4, 4'b0010)
    `CHK("t1_g1_data", od4, 64'hD1)
    `CHK("t1_g1_rdy", rr4, 4'b0010)
    `CHK("t1_g1_valid", ov4, 1'b1)
    tick();
    @(negedge clk);
    `CHK("t1_idle1", busy4, 1'b0)
    `CHK("t1_idle1_oh", oh4, 4'b0000)
    tick();
    @(negedge clk);
    `CHK("t1_g3_idx", gi4, 2'd3)
    `CHK("t1_g3_oh", oh4, 4'b1000)
    `CHK("t1_g3_data", od4, 64'hD3)
    tick();
    @(negedge clk); `CHK("t1_idle2", busy4, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t1_g1b_idx", gi4, 2'd1)
    `CHK("t1_g1b_oh", oh4, 4'b0010)
    tick();
    v4 = '0;
    @(negedge clk); `CHK("t1_idle3", busy4, 1'b0)
    tick();

    // 4-beat burst on requester 2 while requester 0 waits
    v4 = 4'b0101; l4 = '0; or4 = 1'b1;
    @(negedge clk); `CHK("t2_idle", busy4, 1'b0)
    tick();
    for (int k = 0; k < 6; k++) begin
      or4 = rdy_seq[k];
      l4 = (k == 5) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      `CHK("t2_idx", gi4, 2'd2)
      `CHK("t2_oh", oh4, 4'b0100)
      `CHK("t2_rdy", rr4, (rdy_seq[k] ? 4'b0100 : 4'b0000))
      `CHK("t2_valid", ov4, 1'b1)
      `CHK("t2_data", od4, 64'hD2)
      tick();
    end
    or4 = 1'b1; l4 = 4'b0001;
    @(negedge clk); `CHK("t2_idle_after", busy4, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t2_g0_idx", gi4, 2'd0)
    `CHK("t2_g0_oh", oh4, 4'b0001)
    `CHK("t2_g0_data", od4, 64'hD0)
    tick();
    v4 = '0; l4 = '0;
    @(negedge clk); `CHK("t2_idle_end", busy4, 1'b0)
    tick();

    // Valid drop mid-burst on requester 0 with others pending
    v4 = 4'b0001; l4 = '0; or4 = 1'b1;
    @(negedge clk); `CHK("t4_idle", busy4, 1'b0)
    tick();
    v4 = 4'b1111;
    @(negedge clk);
    `CHK("t4_b1_idx", gi4, 2'd0)
    `CHK("t4_b1_valid", ov4, 1'b1)
    tick();
    @(negedge clk); `CHK("t4_b2_valid", ov4, 1'b1)
    tick();
    v4 = 4'b1110;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      `CHK("t4_drop_valid", ov4, 1'b0)
      `CHK("t4_drop_busy", busy4, 1'b1)
      `CHK("t4_drop_idx", gi4, 2'd0)
      `CHK("t4_drop_rdy", rr4, 4'b0001)
      tick();
    end
    v4 = 4'b1111;
    @(negedge clk); `CHK("t4_b3_valid", ov4, 1'b1)
    tick();
    l4 = 4'b0001;
    @(negedge clk);
    `CHK("t4_b4_last", ol4, 1'b1)
    `CHK("t4_b4_idx", gi4, 2'd0)
    tick();
    l4 = '0;
    @(negedge clk); `CHK("t4_idle_end", busy4, 1'b0)
    tick();

    // Reset during beat 2 of a requester-1 burst
    @(negedge clk);
    `CHK("t5_g1_idx", gi4, 2'd1)
    `CHK("t5_g1_data", od4, 64'hD1)
    tick();
    aresetn = 1'b0;
    #1;
    `CHK("t5_rst_busy", busy4, 1'b0)
    `CHK("t5_rst_valid", ov4, 1'b0)
    `CHK("t5_rst_last", ol4, 1'b0)
    `CHK("t5_rst_rdy", rr4, 4'b0000)
    `CHK("t5_rst_oh", oh4, 4'b0000)
    `CHK("t5_rst_idx", gi4, 2'd0)
    `CHK("t5_rst_data", od4, 64'h0)
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk); `CHK("t5_idle", busy4, 1'b0)
    tick();
    l4 = 4'b0001;
    @(negedge clk);
    `CHK("t5_g0_idx", gi4, 2'd0)
    `CHK("t5_g0_oh", oh4, 4'b0001)
    tick();
    v4 = '0; l4 = '0;
    @(negedge clk); `CHK("t5_idle_end", busy4, 1'b0)
    tick();

    // Pointer wrap at N=3
    v3 = 3'b010; l3 = 3'b111; or3 = 1'b1;
    @(negedge clk); `CHK("t3_idle0", busy3, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t3_g1_idx", gi3, 2'd1)
    `CHK("t3_g1_oh", oh3, 3'b010)
    tick();
    v3 = 3'b011;
    @(negedge clk); `CHK("t3_idle1", busy3, 1'b0)
    tick();
    @(negedge clk);
    `CHK("t3_wrap_idx", gi3, 2'd0)
    `CHK("t3_wrap_oh", oh3, 3'b001)
    `CHK("t3_wrap_data", od3, 16'hC0)
    tick();
    @(negedge clk); `CHK("t3_idle2", busy3, 1'b0)
    tick();
    @(negedge clk); `CHK("t3_ptr1_idx", gi3, 2'd1)
    tick();
    v3 = '0;

    // Fairness soak at N=5 with random burst lengths and ready
    v5 = '1;
    for (int b = 0; b < 15; b++) begin
      g = b % 5;
      len = $urandom_range(1, 8);
      tot[g] += len;
      beat = 0;
      cyc = 0;
      for (int i = 0; i < 5; i++) d5[i*16 +: 16] = {4'(i), 12'(seq[i])};
      or5 = 1'b1;
      l5 = '0;
      @(negedge clk); `CHK("t6_bubble", busy5, 1'b0)
      tick();
      while (beat < len && cyc < 40) begin
        or5 = 1'($urandom_range(0, 1));
        l5 = (beat == len - 1) ? 5'b11111 : 5'b00000;
        for (int i = 0; i < 5; i++) d5[i*16 +: 16] = {4'(i), 12'(seq[i])};
        @(negedge clk);
        `CHK("t6_idx", gi5, 3'(g))
        `CHK("t6_valid", ov5, 1'b1)
        `CHK("t6_data", od5, {4'(g), 12'(seq[g])})
        for (int i = 0; i < 5; i++) if (rr5[i]) seq[i]++;
        if (or5) beat++;
        tick();
        cyc++;
      end
      `CHK("t6_burst_bound", beat, len)
    end
    v5 = '0;
    l5 = '0;
    @(negedge clk);
    `CHK("t6_end_idle", busy5, 1'b0)
    for (int i = 0; i < 5; i++) `CHK("t6_beats", seq[i], tot[i])

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`undef CHK
